// File: rtl/mem_readout_sched.sv
// Readout sequencer: drains up to NMEM memories one entry per cycle, in priority order, and delays valid/select to meet read data.
// Optional per-event read budget: define MEM_READOUT_TRUNCATE_EN.
module mem_readout_sched #(
  parameter int NMEM      = 12,
  parameter int ENT_W     = 7,
  parameter int RD_LAT    = 2,
  parameter int MAX_READS = 108
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NMEM*ENT_W-1:0] nent,
  output logic                  rd_en,
  output logic [3:0]            rd_sel,
  output logic [ENT_W-1:0]      rd_addr,
  output logic                  dout_valid,
  output logic [3:0]            dout_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  trunc
);

  if (NMEM < 1 || NMEM > 16 || RD_LAT < 1 || RD_LAT > 4 || MAX_READS < 1) begin : g_bad_cfg
    $error("mem_readout_sched: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, PICK, READ, DRAIN} state_t;

  state_t             state_q;
  logic [ENT_W-1:0]   cnt_q [NMEM];
  logic [NMEM-1:0]    mask_q;
  logic [ENT_W-1:0]   last_q;
  logic               rd_en_q;
  logic [3:0]         rd_sel_q;
  logic [ENT_W-1:0]   rd_addr_q;
  logic [2:0]         dcnt_q;
  logic               busy_q;
  logic               done_q;
  logic [RD_LAT-1:0]  vpipe_q;
  logic [3:0]         spipe_q [RD_LAT];

  logic               pick_any;
  logic [3:0]         pick_idx;
  logic               last_addr;
  logic               start_acc;
  logic               budget_hit;
  logic               cut;

  // Descending scan so the lowest set bit is the one that sticks.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int unsigned i = NMEM; i > 0; i--) begin
      if (mask_q[i-1]) begin
        pick_any = 1'b1;
        pick_idx = 4'(i - 1);
      end
    end
  end

  assign last_addr = (rd_addr_q == last_q);
  assign start_acc = (state_q == IDLE) && start;
  assign cut       = (state_q == READ) && budget_hit && (!last_addr || pick_any);

`ifdef MEM_READOUT_TRUNCATE_EN
  localparam int RC_W = (MAX_READS < 2) ? 1 : $clog2(MAX_READS + 1);

  logic [RC_W-1:0] rcnt_q;
  logic            trunc_q;

  // rcnt_q counts reads already completed; the read on the bus now is number rcnt_q+1.
  assign budget_hit = (rcnt_q == RC_W'(MAX_READS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      trunc_q <= 1'b0;
    end else if (start_acc) begin
      rcnt_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      if (rd_en_q) rcnt_q <= rcnt_q + 1'b1;
      if (cut)     trunc_q <= 1'b1;
    end
  end

  assign trunc = trunc_q;
`else
  assign budget_hit = 1'b0;
  assign trunc      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      last_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_sel_q  <= '0;
      rd_addr_q <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < NMEM; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NMEM; i++) begin
              cnt_q[i]  <= nent[i*ENT_W +: ENT_W];
              mask_q[i] <= |nent[i*ENT_W +: ENT_W];
            end
            busy_q  <= 1'b1;
            state_q <= PICK;
          end
        end
        PICK: begin
          if (!pick_any) begin
            dcnt_q  <= '0;
            state_q <= DRAIN;
          end else begin
            rd_en_q          <= 1'b1;
            rd_sel_q         <= pick_idx;
            rd_addr_q        <= '0;
            last_q           <= cnt_q[pick_idx] - 1'b1;
            mask_q[pick_idx] <= 1'b0;
            state_q          <= READ;
          end
        end
        READ: begin
          if (cut || (last_addr && !pick_any)) begin
            rd_en_q   <= 1'b0;
            rd_sel_q  <= '0;
            rd_addr_q <= '0;
            dcnt_q    <= '0;
            state_q   <= DRAIN;
          end else if (last_addr) begin
            rd_sel_q         <= pick_idx;
            rd_addr_q        <= '0;
            last_q           <= cnt_q[pick_idx] - 1'b1;
            mask_q[pick_idx] <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // The last rd_en left the bus on entry here, so RD_LAT cycles flush the delay pipe.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (dcnt_q == 3'(RD_LAT - 1)) begin
            done_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) spipe_q[i] <= '0;
    end else begin
      vpipe_q[0] <= rd_en_q;
      spipe_q[0] <= rd_sel_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        spipe_q[i] <= spipe_q[i-1];
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_sel     = rd_sel_q;
  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dout_valid = vpipe_q[RD_LAT-1];
  assign dout_sel   = spipe_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_readout_sched.sv
// Bench for mem_readout_sched: expected read list and cycle windows derived per event from the entry counts.
module tb_mem_readout_sched;
  localparam int NMEM   = 12;
  localparam int ENT_W  = 7;
  localparam int RD_LAT = 2;
  localparam int NW     = NMEM * ENT_W;
`ifdef MEM_READOUT_TRUNCATE_EN
  localparam int MAXR    = 4;
  localparam bit TRUNC_ON = 1'b1;
`else
  localparam int MAXR    = 108;
  localparam bit TRUNC_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]       sel;
    logic [ENT_W-1:0] addr;
  } rd_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NW-1:0]    nent = '0;
  logic             rd_en;
  logic [3:0]       rd_sel;
  logic [ENT_W-1:0] rd_addr;
  logic             dout_valid;
  logic [3:0]       dout_sel;
  logic             busy;
  logic             done;
  logic             trunc;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mem_readout_sched #(
    .NMEM(NMEM), .ENT_W(ENT_W), .RD_LAT(RD_LAT), .MAX_READS(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nent(nent),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .dout_valid(dout_valid), .dout_sel(dout_sel),
    .busy(busy), .done(done), .trunc(trunc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NW-1:0] put(input logic [NW-1:0] v, input int unsigned i,
                                        input int unsigned c);
    logic [NW-1:0] r;
    r = v;
    r[i*ENT_W +: ENT_W] = ENT_W'(c);
    return r;
  endfunction

  function automatic logic [NW-1:0] junk();
    return NW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // kick: cycle with an extra start (0 = none); rst_at: cycle to pulse reset (0 = none).
  task automatic run_event(input logic [NW-1:0] nv, input int unsigned kick, input int unsigned rst_at);
    rd_t         q[$];
    int unsigned n, d;
    bit          tr;
    logic [3:0]  exp_ctl;
    for (int i = 0; i < NMEM; i++)
      for (int a = 0; a < int'(nv[i*ENT_W +: ENT_W]); a++)
        q.push_back({4'(i), ENT_W'(a)});
    tr = TRUNC_ON && (q.size() > MAXR);
    while (TRUNC_ON && q.size() > MAXR) void'(q.pop_back());
    n = q.size();
    d = 2 + n + RD_LAT;

    @(negedge clk);
    nent  = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nent  = junk();
    for (int unsigned k = 1; k <= d + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (k == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_outs", {rd_en, rd_sel, rd_addr, dout_valid, dout_sel, busy, done, trunc}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned j = 0; j < d + 2; j++) begin
          @(negedge clk);
          check("post_rst", {busy, done, rd_en, dout_valid}, '0);
        end
        return;
      end
      exp_ctl = {k <= d, k == d, (k >= 2) && (k < 2 + n),
                 (k >= 2 + RD_LAT) && (k < 2 + RD_LAT + n)};
      check("ctl", {busy, done, rd_en, dout_valid}, exp_ctl);
      if ((k >= 2) && (k < 2 + n)) begin
        check("rd_sel", rd_sel, q[k-2].sel);
        check("rd_addr", rd_addr, q[k-2].addr);
      end
      if ((k >= 2 + RD_LAT) && (k < 2 + RD_LAT + n))
        check("dout_sel", dout_sel, q[k-2-RD_LAT].sel);
      if (k == 1) check("trunc_clr", trunc, 0);
      if (k >= d) check("trunc", trunc, tr);
      // Starts during the event and in the done cycle must be ignored.
      start = (k == kick) || (k == d);
      if (start) nent = junk();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] nv;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", {rd_en, rd_sel, rd_addr, dout_valid, dout_sel, busy, done, trunc}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle", {rd_en, dout_valid, busy, done, trunc}, '0);

    run_event(put('0, 0, 3), 0, 0);
    run_event(put(put(put('0, 2, 2), 5, 1), 11, 2), 0, 0);
    run_event('0, 2, 0);
    run_event(put(put('0, 0, 3), 1, 3), 3, 0);
    run_event(put('0, 0, 4), 0, 0);
    run_event(put('0, 7, 127), 0, 0);
    run_event(put('0, 1, 5), 2, 4);
    run_event(put('0, 3, 2), 0, 0);

    for (int e = 0; e < 40; e++) begin
      nv = '0;
      for (int i = 0; i < NMEM; i++)
        if ($urandom_range(0, 1) == 1) nv = put(nv, i, $urandom_range(1, 6));
      run_event(nv,
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
